// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// default I/O port IDs, CAUSE layout and the priority encoder helper.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SVC_CLR = 2'd2,
    SVC     = 2'd3
  } state_t;

  localparam logic [7:0] DEF_MASK_PORT  = 8'h20;
  localparam logic [7:0] DEF_PEND_PORT  = 8'h21;
  localparam logic [7:0] DEF_CAUSE_PORT = 8'h22;

  localparam int CAUSE_VALID_BIT = 7;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Per-bit 3-flop synchronizer with a one-cycle rising-edge pulse taken
// from the last two stages.
module sync_edge_detect #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/intc_responder.sv
// Interrupt controller: latches source edges as pending, masks them, requests
// the control unit's interrupt and records the serviced source in CAUSE.
module intc_responder
  import intc_pkg::*;
#(
  parameter int         N_SRC      = 8,
  parameter logic [7:0] MASK_PORT  = DEF_MASK_PORT,
  parameter logic [7:0] PEND_PORT  = DEF_PEND_PORT,
  parameter logic [7:0] CAUSE_PORT = DEF_CAUSE_PORT
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ_SRC,
  input  logic             I_FLAG,
  input  logic             INT_ACK,
  output logic             INT_R,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_PORT,
  output logic [1:0]       o_dbg_state
);

  state_t           r_state;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [7:0]       r_cause;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [7:0]       w_mask_ext;
  logic [7:0]       w_pend_ext;
  logic [7:0]       w_active_ext;
  logic [7:0]       w_clr_ext;
  logic [7:0]       w_cause_val;
  logic [2:0]       w_winner;
  logic             w_any_active;
  logic             w_ack_take;
  logic             w_wr_mask;
  logic             w_wr_pend;

  sync_edge_detect #(.W(N_SRC)) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_async (IRQ_SRC),
    .o_rise  (w_rise)
  );

  always_comb begin
    w_mask_ext = '0;
    w_pend_ext = '0;
    w_mask_ext[N_SRC-1:0] = r_mask;
    w_pend_ext[N_SRC-1:0] = r_pend;
  end

  assign w_active_ext = w_pend_ext & w_mask_ext;
  assign w_any_active = |w_active_ext;
  assign w_winner     = lowest_set(w_active_ext);
  assign w_ack_take   = (r_state == REQ) && INT_ACK;
  assign w_wr_mask    = IO_STRB && (PORT_ID == MASK_PORT);
  assign w_wr_pend    = IO_STRB && (PORT_ID == PEND_PORT);

  always_comb begin
    w_cause_val = {5'b0, w_winner};
    w_cause_val[CAUSE_VALID_BIT] = 1'b1;
  end

  // Firmware clears are dropped on the acknowledge edge; new edges always win.
  always_comb begin
    w_clr_ext  = '0;
    w_pend_nxt = r_pend;
    if (w_wr_pend && !w_ack_take) w_pend_nxt = w_pend_nxt & ~OUT_PORT[N_SRC-1:0];
    if (w_ack_take && w_any_active) begin
      w_clr_ext[w_winner] = 1'b1;
      w_pend_nxt = w_pend_nxt & ~w_clr_ext[N_SRC-1:0];
    end
    w_pend_nxt = w_pend_nxt | w_rise;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_mask <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_mask) r_mask <= OUT_PORT[N_SRC-1:0];
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_cause <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_active && I_FLAG) r_state <= REQ;
        end
        REQ: begin
          if (INT_ACK) begin
            r_cause <= w_cause_val;
            r_state <= SVC_CLR;
          end else if (!I_FLAG || !w_any_active) begin
            r_state <= IDLE;
          end
        end
        SVC_CLR: begin
          if (!I_FLAG) r_state <= SVC;
        end
        SVC: begin
          if (I_FLAG) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign INT_R       = (r_state == REQ) && !INT_ACK;
  assign o_dbg_state = r_state;

  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == MASK_PORT)       IN_PORT = w_mask_ext;
    else if (PORT_ID == PEND_PORT)  IN_PORT = w_pend_ext;
    else if (PORT_ID == CAUSE_PORT) IN_PORT = r_cause;
  end

endmodule
